// File: rtl/alu_8_pkg.sv
// alu_8_pkg: opcode constants, controller FSM state and the queued command
// record shared by alu_8_ctrl and its command FIFO.
package alu_8_pkg;

    localparam logic [3:0] OP_ADD = 4'hF;
    localparam logic [3:0] OP_SUB = 4'hE;
    localparam logic [3:0] OP_INC = 4'hD;
    localparam logic [3:0] OP_DEC = 4'hC;
    localparam logic [3:0] OP_AND = 4'h7;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic       load;
        logic [3:0] sel;
        logic [7:0] data;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    function automatic cmd_t make_cmd(input logic load, input logic [3:0] sel,
                                      input logic [7:0] data);
        cmd_t c;
        c.load = load;
        c.sel  = sel;
        c.data = data;
        return c;
    endfunction

endpackage

// File: rtl/alu_8_cmd_fifo.sv
// alu_8_cmd_fifo: power-of-two deep command FIFO with a registered occupancy
// count; simultaneous push and pop leave the count unchanged.
module alu_8_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign pop_data = mem[rd_ptr];

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH comes for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && count == CW'(DEPTH)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        !(pop && count == '0));

endmodule

// File: rtl/alu_8_ctrl.sv
// alu_8_ctrl: queues commands and sequences them onto an external combinational
// 8-bit ALU, one response per command. Define ALU_CTRL_ZERO_FLAG_EN for rsp_zero.
module alu_8_ctrl
    import alu_8_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_sel,
    input  logic [7:0] cmd_data,
    input  logic       cmd_load,
    output logic       alu_enable,
    output logic [3:0] alu_sel,
    output logic [7:0] alu_opA,
    output logic [7:0] alu_opB,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_carry,
`ifdef ALU_CTRL_ZERO_FLAG_EN
    output logic       rsp_zero,
`endif
    output logic [7:0] acc,
    output logic       busy,
    output logic [1:0] fsm_state
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // a response transfers on a rising edge where rsp_valid && rsp_ready, and
    // rsp_valid, rsp_data and rsp_carry hold steady until that edge.

    state_t         state;
    cmd_t           head;
    cmd_t           in_cmd;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push;
    logic           pop;
    logic           cur_load;
    logic [7:0]     cur_data;
    logic [7:0]     res_data;
    logic           res_carry;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign cmd_ready  = !rst && !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign pop        = !fifo_empty &&
                        ((state == ST_IDLE) || (state == ST_RESP && rsp_ready));
    assign busy       = (state != ST_IDLE) || !fifo_empty;
    assign fsm_state  = state;
    assign in_cmd     = make_cmd(cmd_load, cmd_sel, cmd_data);

    // Loads bypass the ALU and always clear the carry flag.
    assign res_data   = cur_load ? cur_data : alu_result;
    assign res_carry  = cur_load ? 1'b0 : alu_carry;

    alu_8_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_cmd),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur_load   <= 1'b0;
            cur_data   <= '0;
            acc        <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
            alu_enable <= 1'b0;
            alu_sel    <= '0;
            alu_opA    <= '0;
            alu_opB    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    acc        <= res_data;
                    rsp_data   <= res_data;
                    rsp_carry  <= res_carry;
                    rsp_valid  <= 1'b1;
                    alu_enable <= 1'b0;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= pop ? ST_ISSUE : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A pop always starts an ISSUE cycle, so the ALU drive is loaded here.
            if (pop) begin
                cur_load   <= head.load;
                cur_data   <= head.data;
                alu_sel    <= head.sel;
                alu_opA    <= acc;
                alu_opB    <= head.data;
                alu_enable <= !head.load;
            end
        end
    end

`ifdef ALU_CTRL_ZERO_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_zero <= 1'b0;
        end else if (state == ST_ISSUE) begin
            rsp_zero <= (res_data == 8'h00);
        end
    end
`endif

    a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_carry)));

endmodule

// File: tb/tb_alu_8_ctrl.sv
// tb_alu_8_ctrl: drives alu_8_ctrl against a behavioural ALU and a queue-based
// reference model of command ordering, accumulator and FIFO occupancy.
module tb_alu_8_ctrl;
    import alu_8_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_sel = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_load = 1'b0;
    logic       alu_enable;
    logic [3:0] alu_sel;
    logic [7:0] alu_opA;
    logic [7:0] alu_opB;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_carry;
    logic [7:0] acc;
    logic       busy;
    logic [1:0] fsm_state;
`ifdef ALU_CTRL_ZERO_FLAG_EN
    logic       rsp_zero;
`endif

    alu_8_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sel    (cmd_sel),
        .cmd_data   (cmd_data),
        .cmd_load   (cmd_load),
        .alu_enable (alu_enable),
        .alu_sel    (alu_sel),
        .alu_opA    (alu_opA),
        .alu_opB    (alu_opB),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
`ifdef ALU_CTRL_ZERO_FLAG_EN
        .rsp_zero   (rsp_zero),
`endif
        .acc        (acc),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / reset / bookkeeping ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- external ALU behaviour ----------------
    function automatic logic [8:0] alu_f(input logic [3:0] sel, input logic [7:0] a,
                                         input logic [7:0] b);
        case (sel)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_INC:  return {1'b0, a} + 9'd1;
            OP_DEC:  return {1'b0, a} - 9'd1;
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_NOT:  return {1'b0, ~a};
            default: return 9'd0;
        endcase
    endfunction

    assign {alu_carry, alu_result} = alu_enable ? alu_f(alu_sel, alu_opA, alu_opB) : 9'd0;

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic       load;
        logic [3:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
    } exp_t;

    exp_t       exp_q[$];
    int         fifo_cnt = 0;
    logic       inflight = 1'b0;
    logic [7:0] model_acc = '0;

    task automatic clear_model();
        exp_q.delete();
        fifo_cnt  = 0;
        inflight  = 1'b0;
        model_acc = '0;
    endtask

    always @(negedge clk) begin
        logic       hs;
        logic       took;
        logic [8:0] r;
        exp_t       e;
        if (!rst) begin
            check("busy", busy, (inflight || fifo_cnt != 0));
            check("cmd_ready", cmd_ready, (fifo_cnt < DEPTH));
            if (!inflight) begin
                check("idle_rsp_valid", rsp_valid, 1'b0);
                check("idle_state", fsm_state, ST_IDLE);
            end
            if (!inflight && fifo_cnt == 0) check("idle_acc", acc, model_acc);
            if (rsp_valid) begin
                if (exp_q.size() == 0) check("rsp_unexpected", rsp_valid, 1'b0);
                else begin
                    check("rsp_data", rsp_data, exp_q[0].r);
                    check("rsp_carry", rsp_carry, exp_q[0].c);
                    check("rsp_acc", acc, exp_q[0].r);
`ifdef ALU_CTRL_ZERO_FLAG_EN
                    check("rsp_zero", rsp_zero, (exp_q[0].r == 8'h00));
`endif
                end
            end
            if (alu_enable && !rsp_valid) begin
                if (exp_q.size() == 0) check("alu_enable_unexpected", alu_enable, 1'b0);
                else begin
                    check("alu_enable_load", alu_enable, !exp_q[0].load);
                    check("alu_sel", alu_sel, exp_q[0].sel);
                    check("alu_opA", alu_opA, exp_q[0].a);
                    check("alu_opB", alu_opB, exp_q[0].b);
                end
            end
            // advance the model to the state after the coming rising edge
            hs   = rsp_valid && rsp_ready;
            took = cmd_valid && cmd_ready;
            if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
            if (!inflight) begin
                if (fifo_cnt > 0) begin
                    fifo_cnt--;
                    inflight = 1'b1;
                end
            end else if (hs) begin
                if (fifo_cnt > 0) fifo_cnt--;
                else inflight = 1'b0;
            end
            if (took) begin
                r = cmd_load ? {1'b0, cmd_data} : alu_f(cmd_sel, model_acc, cmd_data);
                e.load = cmd_load;
                e.sel  = cmd_sel;
                e.a    = model_acc;
                e.b    = cmd_data;
                e.r    = r[7:0];
                e.c    = r[8];
                exp_q.push_back(e);
                model_acc = r[7:0];
                fifo_cnt++;
            end
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic push_cmd(input logic ld, input logic [3:0] sel, input logic [7:0] d);
        int   n;
        logic taken;
        n = 0;
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_sel   = sel;
        cmd_data  = d;
        do begin
            @(negedge clk);
            taken = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!taken && n < 100);
        if (!taken) check("push_timeout", taken, 1'b1);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [7:0] d, output logic c);
        int n;
        n = 0;
        rsp_ready = 1'b1;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("rsp_timeout", rsp_valid, 1'b1);
        d = rsp_data;
        c = rsp_carry;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic ld, input logic [3:0] sel, input logic [7:0] d,
                         input logic [7:0] ed, input logic ec, input string nm);
        logic [7:0] gd;
        logic       gc;
        push_cmd(ld, sel, d);
        get_rsp(gd, gc);
        check({nm, "_data"}, gd, ed);
        check({nm, "_carry"}, gc, ec);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rsp_data"}, rsp_data, 8'h00);
        check({tag, "_rsp_carry"}, rsp_carry, 1'b0);
        check({tag, "_alu_enable"}, alu_enable, 1'b0);
        check({tag, "_alu_sel"}, alu_sel, 4'h0);
        check({tag, "_alu_opA"}, alu_opA, 8'h00);
        check({tag, "_alu_opB"}, alu_opB, 8'h00);
        check({tag, "_acc"}, acc, 8'h00);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_state"}, fsm_state, ST_IDLE);
    endtask

    task automatic random_phase(input int n);
        logic taken;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            taken = cmd_valid && cmd_ready;
            @(posedge clk);
            #1;
            if (!cmd_valid || taken) begin
                cmd_valid = ($urandom_range(0, 99) < 60);
                cmd_load  = ($urandom_range(0, 5) == 0);
                cmd_sel   = 4'($urandom_range(0, 15));
                cmd_data  = 8'($urandom_range(0, 255));
            end
            rsp_ready = ($urandom_range(0, 99) < 65);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        while ((busy || rsp_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_model_empty"}, exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    logic       bp_load [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] bp_sel  [6] = '{4'h0, OP_INC, OP_INC, OP_ADD, OP_XOR, 4'h0};
    logic [7:0] bp_data [6] = '{8'h01, 8'h00, 8'h00, 8'h10, 8'hFF, 8'h77};
    logic [7:0] bp_exp  [5] = '{8'h01, 8'h02, 8'h03, 8'h13, 8'hEC};

    initial begin
        int lat;
        int n_acc;
        int n;
        int prev;
        int stray;
`ifdef ALU_CTRL_ZERO_FLAG_EN
        logic [7:0] zd;
        logic       zc;
`endif
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // loads and arithmetic with literal expectations
        do_op(1'b1, 4'h0, 8'h10, 8'h10, 1'b0, "ld10");
        do_op(1'b0, OP_ADD, 8'h05, 8'h15, 1'b0, "add05");
        check("add05_acc", acc, 8'h15);
        do_op(1'b1, 4'h0, 8'hFF, 8'hFF, 1'b0, "ldFF");
        do_op(1'b0, OP_INC, 8'h00, 8'h00, 1'b1, "inc_wrap");
        do_op(1'b1, 4'h0, 8'h00, 8'h00, 1'b0, "ld00");
        do_op(1'b0, OP_SUB, 8'h01, 8'hFF, 1'b1, "sub_borrow");
        do_op(1'b0, OP_DEC, 8'h00, 8'hFE, 1'b0, "dec");
        do_op(1'b1, 4'h0, 8'hF0, 8'hF0, 1'b0, "ldF0");
        do_op(1'b0, OP_XOR, 8'h3C, 8'hCC, 1'b0, "xor3C");
        do_op(1'b0, OP_NOT, 8'h00, 8'h33, 1'b0, "not");
        do_op(1'b0, 4'h8, 8'h5A, 8'h00, 1'b0, "op8");
        do_op(1'b1, 4'h0, 8'hC3, 8'hC3, 1'b0, "ldC3");
        do_op(1'b0, OP_AND, 8'h0F, 8'h03, 1'b0, "and0F");
        do_op(1'b0, OP_OR, 8'h80, 8'h83, 1'b0, "or80");

        // first-response latency from an idle controller
        push_cmd(1'b1, 4'h0, 8'h42);
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        check("latency", lat, 2);
        @(posedge clk);
        #1;

        // back-pressure: six offered, five taken, then in-order drain at 1 per 2 cycles
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            cmd_valid = 1'b1;
            cmd_load  = bp_load[k];
            cmd_sel   = bp_sel[k];
            cmd_data  = bp_data[k];
            @(negedge clk);
            if (cmd_ready) n_acc++;
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_ready", cmd_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("bp_accepted", n_acc, 5);
        rsp_ready = 1'b1;
        prev = 0;
        for (int j = 0; j < 5; j++) begin
            n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 20) begin
                n++;
                @(negedge clk);
            end
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rsp_data", rsp_data, bp_exp[j]);
            if (j > 0) check("bp_gap", cyc - prev, 2);
            prev = cyc;
            @(posedge clk);
            #1;
        end
        drain("bp");

        // randomized traffic against the model
        random_phase(400);
        drain("rand1");

        // reset while a command is in ISSUE with three more queued
        rsp_ready = 1'b0;
        push_cmd(1'b1, 4'h0, 8'h11);
        push_cmd(1'b0, OP_ADD, 8'h01);
        push_cmd(1'b0, OP_ADD, 8'h02);
        push_cmd(1'b0, OP_ADD, 8'h03);
        push_cmd(1'b0, OP_ADD, 8'h04);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("r29_busy_pre", busy, 1'b1);
        check("r29_alu_enable_pre", alu_enable, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        check("r29_no_rsp", stray, 0);
        check("r29_busy_post", busy, 1'b0);
        check("r29_acc_post", acc, 8'h00);
        @(posedge clk);
        #1;

        random_phase(300);
        drain("rand2");

`ifdef ALU_CTRL_ZERO_FLAG_EN
        do_op(1'b1, 4'h0, 8'h01, 8'h01, 1'b0, "z_ld01");
        push_cmd(1'b0, OP_DEC, 8'h00);
        get_rsp(zd, zc);
        check("z_dec_flag", rsp_zero, 1'b1);
        check("z_dec_data", zd, 8'h00);
        push_cmd(1'b0, OP_INC, 8'h00);
        get_rsp(zd, zc);
        check("z_inc_flag", rsp_zero, 1'b0);
        check("z_inc_data", zd, 8'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
